// File: rtl/uart_receiver.sv
// UART receive half: 8N1, oversampled on clken, sticky rdy with frame-error/overrun pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every sampling decision.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bitpos;
  logic [7:0]             r_shift;
  logic                   w_rx_s;
  logic                   w_bit;
  logic [CW-1:0]          w_cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples; with the current sample they form the vote.
  logic [1:0] r_hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_hist <= 2'b11;
    else if (clken) r_hist <= {r_hist[0], w_rx_s};
  end
  assign w_bit = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_bit = w_rx_s;
`endif

  assign rx_busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitpos  <= '0;
      r_shift   <= '0;
      dout      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A completing byte below overrides this clear.
      if (rdy_clr) rdy <= 1'b0;
      case (r_state)
        S_IDLE: if (clken && !w_rx_s) begin
          r_state <= S_START;
          r_cnt   <= '0;
        end
        S_START: if (clken) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == HALF_M1) begin
            if (!w_bit) begin
              r_state  <= S_DATA;
              r_cnt    <= '0;
              r_bitpos <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: if (clken) begin
          if (r_cnt == FULL_M1) begin
            r_shift[r_bitpos] <= w_bit;
            r_cnt             <= '0;
            if (r_bitpos == 3'd7) r_state  <= S_STOP;
            else                  r_bitpos <= r_bitpos + 3'd1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_STOP: if (clken) begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_bit) begin
              dout    <= r_shift;
              rdy     <= 1'b1;
              overrun <= rdy & ~rdy_clr;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames
// against a byte-level reference model (frame in -> expected dout/rdy/pulses out).
module tb_uart_receiver;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, rx, clken, rdy_clr;
  logic [7:0] dout;
  logic       rdy, frame_err, overrun, rx_busy;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clken(clken), .rdy_clr(rdy_clr),
    .dout(dout), .rdy(rdy), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int fe_cnt = 0, ov_cnt = 0, fe_run = 0, ov_run = 0, fe_max = 0, ov_max = 0;
  int fe0, ov0, exp_fe, exp_ov, first_rdy_k;
  int div = 1;
  bit m_rdy = 1'b0;
  logic [7:0] m_dout = 8'h00;

  always @(negedge clk) begin
    if (frame_err) begin fe_cnt++; fe_run++; end else fe_run = 0;
    if (overrun)   begin ov_cnt++; ov_run++; end else ov_run = 0;
    if (fe_run > fe_max) fe_max = fe_run;
    if (ov_run > ov_max) ov_max = ov_run;
  end

  task automatic drive(input bit v, input bit ck);
    rx = v; clken = ck;
    @(negedge clk);
  endtask

  task automatic tick(input bit v);
    for (int d = 0; d < div; d++) drive(v, d == div - 1);
  endtask

  // Drives one 8N1 frame (16 ticks/bit) and advances the reference model.
  task automatic run_frame(input logic [7:0] b, input bit stop_ok, input bit glitch,
                           input int clr_at, input int pad);
    logic [9:0] fr;
    bit v;
    int k;
    fr = {stop_ok, b, 1'b0};
    k = 0;
    fe0 = fe_cnt; ov0 = ov_cnt; first_rdy_k = -1;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 16; s++) begin
        v = fr[i];
        if (glitch && i >= 1 && i <= 8 && s == 7) v = ~v;
        // Release a bad stop bit right after its sample so the tail is not a new start bit.
        if (i == 9 && !stop_ok && s > 7) v = 1'b1;
        rdy_clr = (k == clr_at);
        tick(v);
        if (rdy && first_rdy_k < 0) first_rdy_k = k;
        k++;
      end
    end
    rdy_clr = 1'b0;
    for (int p = 0; p < pad; p++) tick(1'b1);
    if (stop_ok) begin
      exp_fe = 0;
      exp_ov = (m_rdy && clr_at < 0) ? 1 : 0;
      m_rdy  = 1'b1;
      m_dout = (glitch && !MAJ) ? ~b : b;
    end else begin
      exp_fe = 1;
      exp_ov = 0;
    end
  endtask

  task automatic clear_rdy();
    rdy_clr = 1'b1; drive(1'b1, 1'b0);
    rdy_clr = 1'b0; drive(1'b1, 1'b0);
    m_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; clken = 1'b0; rdy_clr = 1'b0;
    repeat (4) @(negedge clk);
    nvec++; if (dout !== 8'h00) begin nerr++; $display("FAIL reset_dout got %h want 00", dout); end
    nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy got %b want 0", rdy); end
    nvec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin nerr++; $display("FAIL reset_pulses got fe=%b ov=%b want 0 0", frame_err, overrun); end
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    rst = 1'b0;
    repeat (4) tick(1'b1);
  endtask

  task automatic test_start_glitch();
    fe0 = fe_cnt;
    repeat (4) tick(1'b0);
    nvec++; if (rx_busy !== 1'b1) begin nerr++; $display("FAIL glitch_busy_in got %b want 1", rx_busy); end
    repeat (12) tick(1'b1);
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL glitch_idle got %b want 0", rx_busy); end
    nvec++; if (rdy !== 1'b0 || dout !== 8'h00) begin nerr++; $display("FAIL glitch_out got rdy=%b dout=%h want 0 00", rdy, dout); end
    nvec++; if (fe_cnt != fe0) begin nerr++; $display("FAIL glitch_fe got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    run_frame(8'h3C, 1'b0, 1'b0, -1, 4);
    nvec++; if (fe_cnt - fe0 != exp_fe) begin nerr++; $display("FAIL ferr_pulse got %0d want %0d", fe_cnt - fe0, exp_fe); end
    nvec++; if (rdy !== m_rdy || dout !== m_dout) begin nerr++; $display("FAIL ferr_out got rdy=%b dout=%h want %b %h", rdy, dout, m_rdy, m_dout); end
    run_frame(8'h81, 1'b1, 1'b0, -1, 4);
    nvec++; if (rdy !== 1'b1 || dout !== 8'h81) begin nerr++; $display("FAIL ferr_recover got rdy=%b dout=%h want 1 81", rdy, dout); end
    nvec++; if (fe_cnt != fe0) begin nerr++; $display("FAIL ferr_recover_fe got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_basic();
    clear_rdy();
    nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL basic_clr got %b want 0", rdy); end
    run_frame(8'hA5, 1'b1, 1'b0, -1, 4);
    nvec++; if (dout !== 8'hA5 || rdy !== 1'b1) begin nerr++; $display("FAIL basic_out got rdy=%b dout=%h want 1 a5", rdy, dout); end
    // Start bit at drive cycle 0, 2 sync flops, stop sample 151 ticks after start detect.
    nvec++; if (first_rdy_k < 153 || first_rdy_k > 154) begin nerr++; $display("FAIL basic_latency got %0d want 153..154", first_rdy_k); end
    nvec++; if (fe_cnt != fe0 || ov_cnt != ov0) begin nerr++; $display("FAIL basic_pulses got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL basic_busy got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    clear_rdy();
    run_frame(8'h00, 1'b1, 1'b0, -1, 0);
    nvec++; if (ov_cnt - ov0 != exp_ov) begin nerr++; $display("FAIL b2b_first_ov got %0d want %0d", ov_cnt - ov0, exp_ov); end
    run_frame(8'hFF, 1'b1, 1'b0, -1, 4);
    nvec++; if (ov_cnt - ov0 != exp_ov) begin nerr++; $display("FAIL b2b_overrun got %0d want %0d", ov_cnt - ov0, exp_ov); end
    nvec++; if (dout !== 8'hFF || rdy !== 1'b1) begin nerr++; $display("FAIL b2b_out got rdy=%b dout=%h want 1 ff", rdy, dout); end
    // rdy_clr lands on the stop-sample cycle: set wins, no overrun.
    run_frame(8'h00, 1'b1, 1'b0, 153, 4);
    nvec++; if (ov_cnt - ov0 != 0) begin nerr++; $display("FAIL b2b_clr_ov got %0d want 0", ov_cnt - ov0); end
    nvec++; if (rdy !== 1'b1 || dout !== 8'h00) begin nerr++; $display("FAIL b2b_clr_out got rdy=%b dout=%h want 1 00", rdy, dout); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    bit saw_rdy;
    b = 8'h96;
    tick(1'b0);
    repeat (15) tick(1'b0);
    for (int i = 0; i < 3; i++) repeat (16) tick(b[i]);
    rst = 1'b1;
    repeat (3) drive(1'b1, 1'b1);
    nvec++; if (dout !== 8'h00 || rdy !== 1'b0 || rx_busy !== 1'b0) begin nerr++; $display("FAIL midrst_out got dout=%h rdy=%b busy=%b want 00 0 0", dout, rdy, rx_busy); end
    rst = 1'b0;
    m_rdy = 1'b0; m_dout = 8'h00;
    saw_rdy = 1'b0;
    repeat (200) begin tick(1'b1); if (rdy) saw_rdy = 1'b1; end
    nvec++; if (saw_rdy) begin nerr++; $display("FAIL midrst_rdy got 1 want 0"); end
    run_frame(8'h5A, 1'b1, 1'b0, -1, 4);
    nvec++; if (dout !== 8'h5A || rdy !== 1'b1) begin nerr++; $display("FAIL midrst_after got rdy=%b dout=%h want 1 5a", rdy, dout); end
  endtask

  task automatic test_majority();
    run_frame(8'hC3, 1'b1, 1'b1, -1, 4);
    nvec++; if (dout !== m_dout) begin nerr++; $display("FAIL majority_dout got %h want %h", dout, m_dout); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit ok;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      div = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) clear_rdy();
      run_frame(b, ok, 1'b0, -1, $urandom_range(0, 3));
      nvec++; if (dout !== m_dout || rdy !== m_rdy) begin nerr++; $display("FAIL rand%0d_out got rdy=%b dout=%h want %b %h", n, rdy, dout, m_rdy, m_dout); end
      nvec++; if (fe_cnt - fe0 != exp_fe || ov_cnt - ov0 != exp_ov) begin nerr++; $display("FAIL rand%0d_pulses got fe=%0d ov=%0d want %0d %0d", n, fe_cnt - fe0, ov_cnt - ov0, exp_fe, exp_ov); end
      nvec++; if (rx_busy !== 1'b0) begin nerr++; $display("FAIL rand%0d_busy got %b want 0", n, rx_busy); end
    end
    div = 1;
  endtask

  task automatic test_pulse_width();
    nvec++; if (fe_max != 1) begin nerr++; $display("FAIL fe_width got %0d want 1", fe_max); end
    nvec++; if (ov_max != 1) begin nerr++; $display("FAIL ov_width got %0d want 1", ov_max); end
  endtask

  initial begin
    test_reset();
    test_start_glitch();
    test_frame_err();
    test_basic();
    test_back_to_back();
    test_reset_midframe();
    test_majority();
    test_random();
    test_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
